// File: rtl/game_pkg.sv
// Shared constants for the reaction-time game: FSM encoding, score limits and
// the target-LED decode used by the controller.
package game_pkg;

  localparam int TARGET_W = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_REACT  = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;

  localparam logic [19:0] HS_INIT   = 20'h99999;
  localparam logic [19:0] SCORE_MAX = 20'h99999;

  function automatic logic [9:0] led_onehot(input logic [TARGET_W-1:0] t);
    return 10'd1 << t;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Start-key conditioner: two-flop synchroniser, stable-sample debounce counter
// and a one-cycle pulse when the debounced key goes from pressed to released.
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_release
);

  localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MS - 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter tracks consecutive samples that disagree with the accepted
  // level; any agreeing sample restarts the count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesised registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= 2'b11;
      level       <= 1'b1;
      cnt         <= '0;
      key_release <= 1'b0;
    end else begin
      sync        <= {sync[0], key_n};
      key_release <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level       <= sync[1];
        cnt         <= '0;
        key_release <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: arms a random countdown, lights a random
// target LED, times the player's switch response and keeps the best score.
module reaction_game_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic        Clk_1K,
  input  logic        Reset_n,
  input  logic        key_start_n,
  input  logic [9:0]  sw,
  input  logic [8:0]  rand_val,
  input  logic        cd_done,
  input  logic [19:0] cur_score,
  output logic        cd_load,
  output logic [8:0]  cd_value,
  output logic        cu_clear,
  output logic        cu_run,
  output logic [9:0]  ledr,
  output logic [19:0] high_score,
  output logic [19:0] disp_bcd,
  output logic [2:0]  state,
  output logic        new_record
);

  logic                key_release;
  logic [9:0]          sw_meta;
  logic [9:0]          sw_s;
  logic [TARGET_W-1:0] target;
  logic                timeout;
  logic [2:0]          state_nx;
  logic                tgt_sw;
  logic                score_max;
  logic                sw8_unused;

  key_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_key_debounce (
    .clk        (Clk_1K),
    .rst_n      (Reset_n),
    .key_n      (key_start_n),
    .key_release(key_release)
  );

  // sw[8] is a spare switch with no game function.
  assign sw8_unused = sw_s[8];
  assign tgt_sw     = sw_s[target];
  assign score_max  = (cur_score == SCORE_MAX);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:   state_nx = key_release ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (key_release)          state_nx = ST_IDLE;
        else if (cd_done && !tgt_sw) state_nx = ST_REACT;
        else                      state_nx = ST_WAIT;
      end
      ST_REACT:  state_nx = (score_max || tgt_sw) ? ST_RESULT : ST_REACT;
      ST_RESULT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_1K or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_meta    <= '0;
      sw_s       <= '0;
      state      <= ST_IDLE;
      high_score <= HS_INIT;
      ledr       <= '0;
      cd_load    <= 1'b0;
      cd_value   <= '0;
      cu_clear   <= 1'b0;
      cu_run     <= 1'b0;
      new_record <= 1'b0;
      disp_bcd   <= '0;
      target     <= '0;
      timeout    <= 1'b0;
    end else begin
      sw_meta    <= sw;
      sw_s       <= sw_meta;
      state      <= state_nx;
      cd_load    <= 1'b0;
      cu_clear   <= 1'b0;
      new_record <= 1'b0;
      ledr       <= (state_nx == ST_REACT) ? led_onehot(target) : '0;
      // Counting starts one cycle after REACT entry, giving cu_clear a clean cycle.
      cu_run     <= (state == ST_REACT) && (state_nx == ST_REACT);
      disp_bcd   <= sw_s[9] ? high_score : cur_score;

      case (state)
        ST_IDLE: begin
          if (key_release) begin
            target   <= rand_val[7:5];
            cd_value <= (rand_val == '0) ? 9'd1 : rand_val;
            cd_load  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (state_nx == ST_REACT) cu_clear <= 1'b1;
        end
        ST_REACT: begin
          if (state_nx == ST_RESULT) timeout <= score_max;
        end
        ST_RESULT: begin
          // BCD digits order the same way as binary, so a plain compare works.
          if (!timeout && (cur_score != '0) && (cur_score < high_score)) begin
            high_score <= cur_score;
            new_record <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl: directed game rounds with a
// scoreboard for cd_load and new_record pulses.
module tb_reaction_game_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_start_n = 1'b1;
  logic [9:0]  sw = '0;
  logic [8:0]  rand_val = '0;
  logic        cd_done = 1'b0;
  logic [19:0] cur_score = '0;
  logic        cd_load;
  logic [8:0]  cd_value;
  logic        cu_clear;
  logic        cu_run;
  logic [9:0]  ledr;
  logic [19:0] high_score;
  logic [19:0] disp_bcd;
  logic [2:0]  state;
  logic        new_record;

  int n_vec = 0;
  int n_err = 0;
  int n_cd_load = 0;
  int n_rec = 0;

  logic [8:0]  cd_q[$];
  logic [19:0] hs_q[$];

  reaction_game_ctrl #(.DEBOUNCE_MS(DEB)) dut (
    .Clk_1K     (clk),
    .Reset_n    (rst_n),
    .key_start_n(key_start_n),
    .sw         (sw),
    .rand_val   (rand_val),
    .cd_done    (cd_done),
    .cur_score  (cur_score),
    .cd_load    (cd_load),
    .cd_value   (cd_value),
    .cu_clear   (cu_clear),
    .cu_run     (cu_run),
    .ledr       (ledr),
    .high_score (high_score),
    .disp_bcd   (disp_bcd),
    .state      (state),
    .new_record (new_record)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int i = 0;
    while (state !== s && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic press_release(input int hold);
    key_start_n = 1'b0;
    tick(hold);
    key_start_n = 1'b1;
  endtask

  // Scoreboard: pulses pop the value the stimulus predicted for them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cd_load) begin
        n_cd_load++;
        check("cd_q_nonempty", 32'(cd_q.size() != 0), 32'd1);
        if (cd_q.size() != 0) check("sb_cd_value", 32'(cd_value), 32'(cd_q.pop_front()));
      end
      if (new_record) begin
        n_rec++;
        check("hs_q_nonempty", 32'(hs_q.size() != 0), 32'd1);
        if (hs_q.size() != 0) check("sb_high_score", 32'(high_score), 32'(hs_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_high_score", 32'(high_score), 32'h99999);
    check("rst_ledr", 32'(ledr), 32'd0);
    check("rst_cu_run", 32'(cu_run), 32'd0);
    check("rst_cd_value", 32'(cd_value), 32'd0);
    check("rst_disp_bcd", 32'(disp_bcd), 32'd0);
    check("rst_new_record", 32'(new_record), 32'd0);

    // Short glitch must not be accepted.
    key_start_n = 1'b0;
    tick(2);
    key_start_n = 1'b1;
    tick(15);
    check("glitch_state", 32'(state), 32'd0);
    check("glitch_no_load", 32'(n_cd_load), 32'd0);

    // Round 1: target 5, record 00342.
    rand_val = 9'h0A5;
    cd_q.push_back(9'h0A5);
    press_release(10);
    wait_state(3'd1, 30, "r1_wait");
    check("r1_cd_load", 32'(cd_load), 32'd1);
    check("r1_cd_value", 32'(cd_value), 32'h0A5);
    tick();
    check("r1_cd_load_pulse", 32'(cd_load), 32'd0);
    check("r1_load_cnt", 32'(n_cd_load), 32'd1);
    cd_done = 1'b1;
    wait_state(3'd2, 10, "r1_react");
    cd_done = 1'b0;
    check("r1_cu_clear", 32'(cu_clear), 32'd1);
    check("r1_ledr", 32'(ledr), 32'h020);
    check("r1_cu_run_entry", 32'(cu_run), 32'd0);
    tick();
    check("r1_cu_run", 32'(cu_run), 32'd1);
    check("r1_cu_clear_pulse", 32'(cu_clear), 32'd0);
    cur_score = 20'h00342;
    hs_q.push_back(20'h00342);
    sw[5] = 1'b1;
    wait_state(3'd3, 10, "r1_result");
    check("r1_result_cu_run", 32'(cu_run), 32'd0);
    tick();
    check("r1_idle", 32'(state), 32'd0);
    check("r1_new_record", 32'(new_record), 32'd1);
    check("r1_high_score", 32'(high_score), 32'h00342);
    sw[5] = 1'b0;
    tick(4);

    // Round 2: slower time, no record; display select.
    cd_q.push_back(9'h0A5);
    press_release(10);
    wait_state(3'd1, 30, "r2_wait");
    cd_done = 1'b1;
    wait_state(3'd2, 10, "r2_react");
    cd_done = 1'b0;
    tick(3);
    cur_score = 20'h00500;
    sw[5] = 1'b1;
    wait_state(3'd3, 10, "r2_result");
    wait_state(3'd0, 5, "r2_idle");
    tick();
    check("r2_high_score", 32'(high_score), 32'h00342);
    check("r2_no_record", 32'(n_rec), 32'd1);
    sw[5] = 1'b0;
    sw[9] = 1'b1;
    tick(3);
    check("r2_disp_high", 32'(disp_bcd), 32'h00342);
    sw[9] = 1'b0;
    tick(3);
    check("r2_disp_cur", 32'(disp_bcd), 32'h00500);

    // Round 3: rand_val 0 becomes 1; abort from WAIT.
    rand_val = 9'h000;
    cd_q.push_back(9'h001);
    press_release(10);
    wait_state(3'd1, 30, "r3_wait");
    check("r3_cd_value", 32'(cd_value), 32'h001);
    tick(3);
    press_release(10);
    wait_state(3'd0, 30, "r3_abort");
    check("r3_high_score", 32'(high_score), 32'h00342);
    check("r3_no_record", 32'(n_rec), 32'd1);

    // Round 4: held switch stalls WAIT, then timeout.
    rand_val = 9'h1E3;
    sw[7] = 1'b1;
    cd_q.push_back(9'h1E3);
    press_release(10);
    wait_state(3'd1, 30, "r4_wait");
    cd_done = 1'b1;
    tick(8);
    check("r4_hold_wait", 32'(state), 32'd1);
    sw[7] = 1'b0;
    wait_state(3'd2, 10, "r4_react");
    cd_done = 1'b0;
    check("r4_ledr", 32'(ledr), 32'h080);
    tick(2);
    cur_score = 20'h99999;
    wait_state(3'd3, 5, "r4_result");
    check("r4_cu_run", 32'(cu_run), 32'd0);
    wait_state(3'd0, 5, "r4_idle");
    tick();
    check("r4_high_score", 32'(high_score), 32'h00342);
    check("r4_no_record", 32'(n_rec), 32'd1);

    // Round 5: asynchronous reset during REACT.
    rand_val = 9'h0A5;
    cur_score = 20'h00000;
    cd_q.push_back(9'h0A5);
    press_release(10);
    wait_state(3'd1, 30, "r5_wait");
    cd_done = 1'b1;
    wait_state(3'd2, 10, "r5_react");
    cd_done = 1'b0;
    tick(2);
    check("r5_cu_run", 32'(cu_run), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r5_rst_state", 32'(state), 32'd0);
    check("r5_rst_ledr", 32'(ledr), 32'd0);
    check("r5_rst_cu_run", 32'(cu_run), 32'd0);
    check("r5_rst_high_score", 32'(high_score), 32'h99999);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    check("cd_q_empty", 32'(cd_q.size()), 32'd0);
    check("hs_q_empty", 32'(hs_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
